// File: rtl/isp_pkg.sv
// Shared types for the ISP output frame controller: FSM states and pixel format codes.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package isp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FMT_RAW16  = 2'b00,
        FMT_RGB24  = 2'b01,
        FMT_RGB30  = 2'b10,
        FMT_YUV422 = 2'b11
    } fmt_t;

    // Format code held in the shadow register out of reset.
    localparam fmt_t FMT_RESET = FMT_RGB24;

endpackage

// File: rtl/isp_pipe_reg.sv
// One-entry valid/ready output register carrying an opaque W-bit payload.
// Latency: 1 cycle from input handshake to o_vld.
// Backpressure: accepts a new beat only when empty or draining this cycle; payload holds while stalled.
module isp_pipe_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_vld,
    output logic         o_rdy,
    input  logic [W-1:0] i_dat,
    output logic         o_vld,
    input  logic         i_rdy,
    output logic [W-1:0] o_dat
);

    logic         r_vld;
    logic [W-1:0] r_dat;

    assign o_rdy = !r_vld || i_rdy;
    assign o_vld = r_vld;
    assign o_dat = r_dat;

    // Load a new beat when the slot is free or being emptied; otherwise hold the current beat.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (o_rdy) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_dat <= i_dat;
            end
        end
    end

endmodule

// File: rtl/isp_out_frame_ctrl.sv
// Frame controller: tags incoming pixels with x/y/sof/eol/eof and sequences whole frames.
// Latency: 1 cycle from input handshake to fmt_valid_o, full throughput.
// Backpressure: in_ready_o follows the output register's free slot, only while a frame is active.
module isp_out_frame_ctrl #(
    parameter int PIX_W      = 24,
    parameter int MAX_WIDTH  = 3840,
    parameter int MAX_HEIGHT = 2160,
    parameter int CNT_W      = 13
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cfg_start_i,
    input  logic             cfg_stop_i,
    input  logic             cfg_mode_i,
    input  logic [1:0]       cfg_format_i,
    input  logic [CNT_W-1:0] cfg_width_i,
    input  logic [CNT_W-1:0] cfg_height_i,
    input  logic [PIX_W-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [PIX_W-1:0] fmt_data_o,
    output logic             fmt_valid_o,
    input  logic             fmt_ready_i,
    output logic [1:0]       fmt_format_o,
    output logic [CNT_W-1:0] pixel_x_o,
    output logic [CNT_W-1:0] pixel_y_o,
    output logic             sof_o,
    output logic             eol_o,
    output logic             eof_o,
    output logic             busy_o,
    output logic [15:0]      frame_cnt_o,
    output logic             frame_done_o,
    output logic             err_cfg_o
);

    import isp_pkg::*;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
        logic             sof;
        logic             eol;
        logic             eof;
    } beat_t;

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WIDTH);
    localparam logic [CNT_W-1:0] MAX_H = CNT_W'(MAX_HEIGHT);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_width, r_height, r_x, r_y;
    logic [1:0]       r_format;
    logic             r_mode, r_stop_pending, r_err_cfg, r_frame_done;
    logic [15:0]      r_frame_cnt;
    logic             w_cfg_bad, w_pipe_rdy, w_in_acc, w_out_acc, w_done_acc;
    logic             w_last_x, w_last_y, w_stop_eff;
    beat_t            w_beat_in, w_beat_out;

    assign w_cfg_bad  = (cfg_width_i == '0) || (cfg_height_i == '0) ||
                        (cfg_width_i > MAX_W) || (cfg_height_i > MAX_H);
    assign w_last_x   = (r_x == r_width - ONE);
    assign w_last_y   = (r_y == r_height - ONE);
    assign in_ready_o = (r_state == ST_ACTIVE) && w_pipe_rdy;
    assign w_in_acc   = in_valid_i && in_ready_o;
    assign w_out_acc  = fmt_valid_o && fmt_ready_i;
    assign w_done_acc = (r_state == ST_DONE) && w_out_acc && w_beat_out.eof;
    // A stop arriving in the same cycle the frame closes still prevents the next frame.
    assign w_stop_eff = r_stop_pending || cfg_stop_i;

    assign w_beat_in.data = in_data_i;
    assign w_beat_in.x    = r_x;
    assign w_beat_in.y    = r_y;
    assign w_beat_in.sof  = (r_x == '0) && (r_y == '0);
    assign w_beat_in.eol  = w_last_x;
    assign w_beat_in.eof  = w_last_x && w_last_y;

    isp_pipe_reg #(
        .W ($bits(beat_t))
    ) u_pipe (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
        .i_vld   (w_in_acc),
        .o_rdy   (w_pipe_rdy),
        .i_dat   (w_beat_in),
        .o_vld   (fmt_valid_o),
        .i_rdy   (fmt_ready_i),
        .o_dat   (w_beat_out)
    );

    assign fmt_data_o   = w_beat_out.data;
    assign pixel_x_o    = w_beat_out.x;
    assign pixel_y_o    = w_beat_out.y;
    assign sof_o        = w_beat_out.sof;
    assign eol_o        = w_beat_out.eol;
    assign eof_o        = w_beat_out.eof;
    assign fmt_format_o = r_format;
    assign busy_o       = (r_state != ST_IDLE);
    assign frame_cnt_o  = r_frame_cnt;
    assign frame_done_o = r_frame_done;
    assign err_cfg_o    = r_err_cfg;

    // Frame sequencing: wait for start, validate config, stream pixels, wait for eof to drain.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (cfg_start_i && !cfg_stop_i) w_state_nxt = ST_LOAD;
            ST_LOAD:   w_state_nxt = w_cfg_bad ? ST_IDLE : ST_ACTIVE;
            ST_ACTIVE: if (w_in_acc && w_beat_in.eof) w_state_nxt = ST_DONE;
            ST_DONE:   if (w_done_acc) w_state_nxt = (!r_mode && !w_stop_eff) ? ST_LOAD : ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Shadow config captured once per frame in LOAD; position counters advance per accepted pixel.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_width   <= '0;
            r_height  <= '0;
            r_format  <= FMT_RESET;
            r_mode    <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_err_cfg <= 1'b0;
        end else if (r_state == ST_LOAD) begin
            r_width   <= cfg_width_i;
            r_height  <= cfg_height_i;
            r_format  <= cfg_format_i;
            r_mode    <= cfg_mode_i;
            r_x       <= '0;
            r_y       <= '0;
            r_err_cfg <= w_cfg_bad;
        end else if (w_in_acc) begin
            if (w_last_x) begin
                r_x <= '0;
                r_y <= w_last_y ? '0 : r_y + ONE;
            end else begin
                r_x <= r_x + ONE;
            end
        end
    end

    // Stop requests outside IDLE are remembered until the controller returns to IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)                                 r_stop_pending <= 1'b0;
        else if (w_state_nxt == ST_IDLE)              r_stop_pending <= 1'b0;
        else if (cfg_stop_i && r_state != ST_IDLE)    r_stop_pending <= 1'b1;
    end

    // Completed-frame pulse and counter, triggered when the eof beat leaves downstream.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_frame_done <= w_done_acc;
            if (w_done_acc) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_isp_out_frame_ctrl.sv
// Randomised scoreboard bench for isp_out_frame_ctrl.
// Latency: expected beats are queued at planning time and popped on each output handshake.
// Backpressure: downstream ready is driven always-on, toggling or random per test.
module tb_isp_out_frame_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i, cfg_start_i, cfg_stop_i, cfg_mode_i;
    logic [1:0]  cfg_format_i;
    logic [12:0] cfg_width_i, cfg_height_i;
    logic [23:0] in_data_i;
    logic        in_valid_i, in_ready_o;
    logic [23:0] fmt_data_o;
    logic        fmt_valid_o, fmt_ready_i;
    logic [1:0]  fmt_format_o;
    logic [12:0] pixel_x_o, pixel_y_o;
    logic        sof_o, eol_o, eof_o, busy_o, frame_done_o, err_cfg_o;
    logic [15:0] frame_cnt_o;

    typedef struct packed {
        logic [23:0] d;
        logic [12:0] x;
        logic [12:0] y;
        logic        sof;
        logic        eol;
        logic        eof;
        logic [1:0]  fmt;
    } beat_t;

    beat_t       sb[$];
    logic [23:0] pix_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          exp_frames = 0;
    int          rdy_mode = 0;
    logic        pend_done = 1'b0;
    logic        hold_pend = 1'b0;
    beat_t       hold_snap;

    always #5 clk_i = ~clk_i;

    isp_out_frame_ctrl dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i),
        .cfg_mode_i(cfg_mode_i), .cfg_format_i(cfg_format_i),
        .cfg_width_i(cfg_width_i), .cfg_height_i(cfg_height_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .fmt_data_o(fmt_data_o), .fmt_valid_o(fmt_valid_o), .fmt_ready_i(fmt_ready_i),
        .fmt_format_o(fmt_format_o), .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o),
        .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o), .busy_o(busy_o),
        .frame_cnt_o(frame_cnt_o), .frame_done_o(frame_done_o), .err_cfg_o(err_cfg_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Downstream ready generator.
    always @(posedge clk_i) begin
        #1;
        case (rdy_mode)
            0:       fmt_ready_i = 1'b1;
            1:       fmt_ready_i = ~fmt_ready_i;
            default: fmt_ready_i = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Monitor: pops the scoreboard on each output handshake, checks stall hold and frame_done timing.
    always @(negedge clk_i) begin
        beat_t cur, e;
        cur = {fmt_data_o, pixel_x_o, pixel_y_o, sof_o, eol_o, eof_o, fmt_format_o};
        if (!rst_n_i) begin
            pend_done = 1'b0;
            hold_pend = 1'b0;
        end else begin
            if (frame_done_o || pend_done) check("frame_done", 64'(frame_done_o), 64'(pend_done));
            if (hold_pend) check("stall_hold", {fmt_valid_o, cur}, {1'b1, hold_snap});
            pend_done = 1'b0;
            hold_pend = 1'b0;
            if (fmt_valid_o && fmt_ready_i) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_beat: got %0h, expected no beat (t=%0t)", cur, $time);
                end else begin
                    e = sb.pop_front();
                    check("beat", 64'(cur), 64'(e));
                    pend_done = e.eof;
                end
            end else if (fmt_valid_o) begin
                hold_pend = 1'b1;
                hold_snap = cur;
            end
        end
    end

    // Reference model: a w x h frame is w*h pixels in raster order.
    task automatic plan_frame(input int w, input int h, input logic [1:0] f);
        beat_t b;
        logic [23:0] p;
        pix_q.delete();
        for (int k = 0; k < w * h; k++) begin
            p     = 24'($urandom());
            pix_q.push_back(p);
            b.d   = p;
            b.x   = 13'(k % w);
            b.y   = 13'(k / w);
            b.sof = (k == 0);
            b.eol = ((k % w) == w - 1);
            b.eof = (k == w * h - 1);
            b.fmt = f;
            sb.push_back(b);
        end
    endtask

    task automatic start(input int w, input int h, input logic [1:0] f, input logic mode);
        cfg_width_i  = 13'(w);
        cfg_height_i = 13'(h);
        cfg_format_i = f;
        cfg_mode_i   = mode;
        cfg_start_i  = 1'b1;
        @(posedge clk_i); #1;
        cfg_start_i  = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic drive(input int n, input bit rnd, input int stop_at);
        int i = 0;
        int budget = 40 * n + 200;
        bit acc;
        while (i < n && budget > 0) begin
            in_valid_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data_i  = pix_q[i];
            @(negedge clk_i);
            acc = in_valid_i && in_ready_o;
            @(posedge clk_i); #1;
            cfg_stop_i = 1'b0;
            if (acc) begin
                if (i == stop_at) cfg_stop_i = 1'b1;
                i++;
            end
            budget--;
        end
        in_valid_i = 1'b0;
        if (cfg_stop_i) begin
            @(posedge clk_i); #1;
            cfg_stop_i = 1'b0;
        end
        if (i < n) begin
            n_chk++;
            $display("FAIL drive_timeout: accepted %0d, expected %0d", i, n);
        end
    endtask

    task automatic wait_idle();
        int b = 20000;
        @(negedge clk_i);
        while (busy_o && b > 0) begin
            @(negedge clk_i);
            b--;
        end
        check("idle_busy", 64'(busy_o), 64'd0);
        check("frame_cnt", 64'(frame_cnt_o), 64'(exp_frames));
        check("sb_drained", 64'(sb.size()), 64'd0);
        @(posedge clk_i); #1;
    endtask

    task automatic check_reset();
        check("rst_valid", 64'(fmt_valid_o), 64'd0);
        check("rst_data", 64'(fmt_data_o), 64'd0);
        check("rst_xy", {pixel_x_o, pixel_y_o}, 64'd0);
        check("rst_sidebands", {sof_o, eol_o, eof_o}, 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt_o), 64'd0);
        check("rst_frame_done", 64'(frame_done_o), 64'd0);
        check("rst_err", 64'(err_cfg_o), 64'd0);
        check("rst_format", 64'(fmt_format_o), 64'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n_i = 1'b0; cfg_start_i = 1'b0; cfg_stop_i = 1'b0; cfg_mode_i = 1'b0;
        cfg_format_i = 2'd0; cfg_width_i = '0; cfg_height_i = '0;
        in_data_i = '0; in_valid_i = 1'b0; fmt_ready_i = 1'b1;
        repeat (2) begin @(posedge clk_i); #1; end
        @(negedge clk_i);
        check_reset();
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // 4x2 single frame, full throughput.
        rdy_mode = 0;
        plan_frame(4, 2, 2'd1); start(4, 2, 2'd1, 1'b1); drive(8, 0, -1);
        exp_frames++; wait_idle();

        // Same frame with downstream ready toggling every cycle.
        rdy_mode = 1;
        plan_frame(4, 2, 2'd1); start(4, 2, 2'd1, 1'b1); drive(8, 0, -1);
        exp_frames++; wait_idle();

        // Continuous mode: format changed mid-frame 1, stop during frame 2.
        rdy_mode = 0;
        plan_frame(3, 1, 2'd0); start(3, 1, 2'd0, 1'b0);
        cfg_format_i = 2'd3;
        drive(3, 0, -1);
        plan_frame(3, 1, 2'd3); drive(3, 0, 0);
        exp_frames += 2; wait_idle();
        repeat (20) begin @(posedge clk_i); #1; end
        check("cont_busy_after", 64'(busy_o), 64'd0);
        check("cont_frame_cnt", 64'(frame_cnt_o), 64'(exp_frames));

        // Invalid configurations.
        start(0, 2, 2'd1, 1'b1);
        @(negedge clk_i);
        check("err_w0", {err_cfg_o, busy_o}, 64'h2);
        @(posedge clk_i); #1;
        start(3841, 1, 2'd1, 1'b1);
        @(negedge clk_i);
        check("err_w3841", {err_cfg_o, busy_o}, 64'h2);
        @(posedge clk_i); #1;
        start(1, 2161, 2'd1, 1'b1);
        @(negedge clk_i);
        check("err_h2161", {err_cfg_o, busy_o}, 64'h2);
        @(posedge clk_i); #1;
        plan_frame(2, 1, 2'd2); start(2, 1, 2'd2, 1'b1);
        @(negedge clk_i);
        check("err_cleared", 64'(err_cfg_o), 64'd0);
        @(posedge clk_i); #1;
        drive(2, 0, -1); exp_frames++; wait_idle();

        // Start and stop together in IDLE.
        cfg_start_i = 1'b1; cfg_stop_i = 1'b1;
        @(posedge clk_i); #1;
        cfg_start_i = 1'b0; cfg_stop_i = 1'b0;
        @(negedge clk_i);
        check("startstop_busy", 64'(busy_o), 64'd0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("startstop_busy_later", 64'(busy_o), 64'd0);
        @(posedge clk_i); #1;

        // Randomised frames with random valid and ready.
        rdy_mode = 2;
        for (int t = 0; t < 6; t++) begin
            int w, h;
            logic [1:0] f;
            w = $urandom_range(1, 6);
            h = $urandom_range(1, 4);
            f = 2'($urandom_range(0, 3));
            plan_frame(w, h, f); start(w, h, f, 1'b1); drive(w * h, 1, -1);
            exp_frames++; wait_idle();
        end

        // Dimension limits.
        rdy_mode = 0;
        plan_frame(3840, 1, 2'd2); start(3840, 1, 2'd2, 1'b1); drive(3840, 0, -1);
        exp_frames++; wait_idle();
        plan_frame(1, 2160, 2'd3); start(1, 2160, 2'd3, 1'b1); drive(2160, 0, -1);
        exp_frames++; wait_idle();

        // Reset in the middle of a frame.
        plan_frame(4, 2, 2'd1); start(4, 2, 2'd1, 1'b1); drive(3, 0, -1);
        rst_n_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check_reset();
        sb.delete();
        exp_frames = 0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        plan_frame(4, 2, 2'd1); start(4, 2, 2'd1, 1'b1); drive(8, 0, -1);
        exp_frames++; wait_idle();

        repeat (5) begin @(posedge clk_i); #1; end
        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
